// File: rtl/pic_pkg.sv
// Shared types and the rotating priority search used by the interrupt controller.
package pic_pkg;

  typedef enum logic {StIdle, StWaitAck2} pic_state_e;

  localparam int unsigned DEF_NUM_IRQ = 8;
  localparam int unsigned RESET_LAST  = DEF_NUM_IRQ - 1;

  // Returns {found, idx}; priority runs base+1, base+2, ... modulo n.
  function automatic logic [5:0] prio_find(input logic [31:0] vec, input logic [4:0] base,
                                           input int unsigned n);
    logic [31:0] rot;
    int unsigned start;
    int unsigned j;
    logic        found;
    logic [4:0]  pos;
    start = 32'(base) + 1;
    if (start >= n) start = 0;
    rot = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(n)) begin
        j = 32'(i) + start;
        if (j >= n) j = j - n;
        rot[i] = vec[j[4:0]];
      end
    end
    found = 1'b0;
    pos   = '0;
    for (int i = 31; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = 5'(i);
      end
    end
    j = 32'(pos) + start;
    if (j >= n) j = j - n;
    return {found, j[4:0]};
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotating find-first: highest-priority set bit and its rank.
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_vec,
  input  logic [ID_W-1:0]    i_base,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx,
  output logic [ID_W-1:0]    o_rank
);

  logic [5:0] w_res;

  assign w_res   = prio_find(32'(i_vec), 5'(i_base), NUM_IRQ);
  assign o_found = w_res[5];
  assign o_idx   = ID_W'(w_res[4:0]);

  // Rank 0 is the highest priority slot in the current rotation.
  always_comb begin
    int unsigned s;
    int unsigned r;
    s = 32'(i_base) + 1;
    if (s >= NUM_IRQ) s = 0;
    r = 32'(w_res[4:0]);
    if (r >= s) r = r - s;
    else        r = r + NUM_IRQ - s;
    o_rank = ID_W'(r);
  end

endmodule

// File: rtl/pic_core_n.sv
// 8259-style interrupt core: IRR capture, priority resolution, ISR tracking and INTA sequence.
module pic_core_n
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ),
  parameter int unsigned VEC_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_IRQ-1:0]    i_irq_lines,
  input  logic [NUM_IRQ-1:0]    i_level_mode,
  input  logic [NUM_IRQ-1:0]    i_irq_mask,
  input  logic                  i_rotate_en,
  input  logic                  i_aeoi_en,
  input  logic [VEC_W-ID_W-1:0] i_vector_base,
  input  logic                  i_inta_strobe,
  input  logic                  i_eoi_valid,
  input  logic                  i_eoi_specific,
  input  logic [ID_W-1:0]       i_eoi_id,
  output logic                  o_int_out,
  output logic                  o_vector_valid,
  output logic [VEC_W-1:0]      o_vector_out,
  output logic                  o_spurious,
  output logic [NUM_IRQ-1:0]    o_irr,
  output logic [NUM_IRQ-1:0]    o_isr,
  output logic [ID_W-1:0]       o_last_serviced
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IRQ - 1);

  pic_state_e         r_state;
  logic [NUM_IRQ-1:0] r_irr, r_isr, r_sample;
  logic [ID_W-1:0]    r_last, r_id;
  logic               r_spur_pend, r_int, r_vvalid, r_spur;
  logic [VEC_W-1:0]   r_vec;

  logic [ID_W-1:0]    w_base, w_cand_idx, w_cand_rank, w_isr_idx, w_isr_rank, w_eoi_idx;
  logic [ID_W-1:0]    w_last_d;
  logic               w_cand_found, w_isr_found, w_ack1, w_ack2, w_eoi_hit, w_int_d;
  logic [NUM_IRQ-1:0] w_irr_d, w_isr_d;
  pic_state_e         w_state_d;

  assign w_base = i_rotate_en ? r_last : LAST_ID;

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_cand (
    .i_vec   (r_irr & ~i_irq_mask),
    .i_base  (w_base),
    .o_found (w_cand_found),
    .o_idx   (w_cand_idx),
    .o_rank  (w_cand_rank)
  );

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr (
    .i_vec   (r_isr),
    .i_base  (w_base),
    .o_found (w_isr_found),
    .o_idx   (w_isr_idx),
    .o_rank  (w_isr_rank)
  );

  always_comb begin
    w_ack1    = i_inta_strobe && (r_state == StIdle);
    w_ack2    = i_inta_strobe && (r_state == StWaitAck2);
    w_state_d = w_ack1 ? StWaitAck2 : (w_ack2 ? StIdle : r_state);
    w_int_d   = (w_state_d == StIdle) && w_cand_found &&
                (!w_isr_found || (w_cand_rank < w_isr_rank));

    w_eoi_hit = 1'b0;
    w_eoi_idx = w_isr_idx;
    if (i_eoi_valid) begin
      if (i_eoi_specific) begin
        if ((32'(i_eoi_id) < NUM_IRQ) && r_isr[i_eoi_id]) begin
          w_eoi_hit = 1'b1;
          w_eoi_idx = i_eoi_id;
        end
      end else begin
        w_eoi_hit = w_isr_found;
      end
    end

    // A new edge is ORed in after the ack1 clear so it is never lost.
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (i_level_mode[i]) begin
        w_irr_d[i] = i_irq_lines[i];
      end else begin
        w_irr_d[i] = (r_irr[i] && !(w_ack1 && w_cand_found && (w_cand_idx == ID_W'(i)))) ||
                     (i_irq_lines[i] && !r_sample[i]);
      end
    end

    w_isr_d  = r_isr;
    w_last_d = r_last;
    if (w_ack2 && i_aeoi_en && !r_spur_pend) begin
      w_isr_d[r_id] = 1'b0;
      if (i_rotate_en) w_last_d = r_id;
    end
    if (w_eoi_hit) begin
      w_isr_d[w_eoi_idx] = 1'b0;
      if (i_rotate_en) w_last_d = w_eoi_idx;
    end
    if (w_ack1 && w_cand_found) w_isr_d[w_cand_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_irr       <= '0;
      r_isr       <= '0;
      r_sample    <= '0;
      r_last      <= LAST_ID;
      r_id        <= '0;
      r_spur_pend <= 1'b0;
      r_int       <= 1'b0;
      r_vvalid    <= 1'b0;
      r_spur      <= 1'b0;
      r_vec       <= '0;
    end else begin
      r_sample <= i_irq_lines;
      r_irr    <= w_irr_d;
      r_isr    <= w_isr_d;
      r_last   <= w_last_d;
      r_int    <= w_int_d;
      r_vvalid <= 1'b0;
      r_spur   <= 1'b0;
      r_vec    <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_ack1) begin
            r_id        <= w_cand_found ? w_cand_idx : LAST_ID;
            r_spur_pend <= !w_cand_found;
            r_state     <= StWaitAck2;
          end
        end
        StWaitAck2: begin
          if (w_ack2) begin
            r_vvalid    <= 1'b1;
            r_vec       <= {i_vector_base, r_id};
            r_spur      <= r_spur_pend;
            r_spur_pend <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_int_out       = r_int;
  assign o_vector_valid  = r_vvalid;
  assign o_vector_out    = r_vec;
  assign o_spurious      = r_spur;
  assign o_irr           = r_irr;
  assign o_isr           = r_isr;
  assign o_last_serviced = r_last;

endmodule
